// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state encoding, command opcodes and sequencer states for the JTAG host
package jtag_pkg;
    // IEEE 1149.1 TAP controller state encoding
    localparam logic [3:0] TAP_EX2DR   = 4'h0;
    localparam logic [3:0] TAP_EX1DR   = 4'h1;
    localparam logic [3:0] TAP_SHDR    = 4'h2;
    localparam logic [3:0] TAP_PAUSEDR = 4'h3;
    localparam logic [3:0] TAP_SELIR   = 4'h4;
    localparam logic [3:0] TAP_UPDDR   = 4'h5;
    localparam logic [3:0] TAP_CAPDR   = 4'h6;
    localparam logic [3:0] TAP_SELDR   = 4'h7;
    localparam logic [3:0] TAP_EX2IR   = 4'h8;
    localparam logic [3:0] TAP_EX1IR   = 4'h9;
    localparam logic [3:0] TAP_SHIR    = 4'hA;
    localparam logic [3:0] TAP_PAUSEIR = 4'hB;
    localparam logic [3:0] TAP_RTI     = 4'hC;
    localparam logic [3:0] TAP_UPDIR   = 4'hD;
    localparam logic [3:0] TAP_CAPIR   = 4'hE;
    localparam logic [3:0] TAP_TLR     = 4'hF;

    typedef enum logic [1:0] {OP_RESET, OP_IDLE, OP_SHIFT_IR, OP_SHIFT_DR} op_t;

    typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_WALK, S_SHIFT, S_EXIT, S_DONE} seq_t;
endpackage

// File: rtl/jtag_tap_next.sv
// jtag_tap_next: combinational TAP controller next-state function
//   state     in  current TAP state
//   tms       in  TMS value sampled on the rising TCK edge
//   state_nxt out TAP state after that edge
module jtag_tap_next
    import jtag_pkg::*;
(
    input  logic [3:0] state,
    input  logic       tms,
    output logic [3:0] state_nxt
);
    always_comb begin
        case (state)
            TAP_TLR:     state_nxt = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:     state_nxt = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR:   state_nxt = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR:   state_nxt = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:    state_nxt = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR:   state_nxt = tms ? TAP_UPDDR : TAP_PAUSEDR;
            TAP_PAUSEDR: state_nxt = tms ? TAP_EX2DR : TAP_PAUSEDR;
            TAP_EX2DR:   state_nxt = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR:   state_nxt = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR:   state_nxt = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR:   state_nxt = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:    state_nxt = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR:   state_nxt = tms ? TAP_UPDIR : TAP_PAUSEIR;
            TAP_PAUSEIR: state_nxt = tms ? TAP_EX2IR : TAP_PAUSEIR;
            TAP_EX2IR:   state_nxt = tms ? TAP_UPDIR : TAP_SHIR;
            default:     state_nxt = tms ? TAP_SELDR : TAP_RTI;
        endcase
    end
endmodule

// File: rtl/jtag_host_shifter.sv
// jtag_host_shifter: JTAG initiator turning RESET/IDLE/SHIFT_IR/SHIFT_DR commands into TCK/TMS/TDI waveforms
//   clk, rst                 system clock, async active-high reset
//   cmd_valid/ready/op/len/data  command handshake (len clamped to MAX_LEN, data LSB first)
//   rsp_valid/rsp_data       one-cycle completion pulse with captured TDO
//   busy, tap_state          host busy flag and tracked target TAP state
//   tck, tms, tdi, tdo       board-level JTAG pins
module jtag_host_shifter
    import jtag_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic [3:0]         tap_state,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [5:0] ML = 6'(MAX_LEN);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    seq_t st, st_n, st_0, follow;
    op_t op, op_c;
    logic [5:0] len, cnt, cnt_n, len_c;
    logic [MAX_LEN-1:0] data, cap;
    logic [15:0] div;
    logic [3:0] tap_nxt;
    logic last;

    // TCK count of the segment a sequencer state emits
    function automatic logic [5:0] seg_len(seq_t s, op_t o, logic [5:0] l);
        return s == S_PREFIX ? 6'd1 : s == S_EXIT ? 6'd2 : s == S_SHIFT ? l :
               o == OP_RESET ? 6'd6 : o == OP_IDLE ? l : o == OP_SHIFT_DR ? 6'd3 : 6'd4;
    endfunction

    // TMS for TCK number c of segment s
    function automatic logic tms_of(seq_t s, op_t o, logic [5:0] l, logic [5:0] c);
        return s == S_EXIT ? c == 6'd0 : s == S_SHIFT ? c == l - 6'd1 :
               s != S_WALK ? 1'b0 : o == OP_RESET ? c < 6'd5 :
               o == OP_SHIFT_DR ? c == 6'd0 : o == OP_SHIFT_IR ? c < 6'd2 : 1'b0;
    endfunction

    jtag_tap_next u_tap (.state(tap_state), .tms(tms), .state_nxt(tap_nxt));

    assign busy   = ~cmd_ready;
    assign op_c   = op_t'(cmd_op);
    assign len_c  = cmd_len > ML ? ML : cmd_len;
    // zero-length IDLE/SHIFT emit no TCKs at all; a TLR start needs one TMS=0 clock to reach RTI
    assign st_0   = op_c == OP_RESET ? S_WALK : len_c == 6'd0 ? S_DONE :
                    tap_state == TAP_TLR ? S_PREFIX : S_WALK;
    assign last   = cnt == seg_len(st, op, len) - 6'd1;
    assign follow = st == S_PREFIX ? S_WALK :
                    st == S_WALK ? ((op == OP_RESET || op == OP_IDLE) ? S_DONE : S_SHIFT) :
                    st == S_SHIFT ? S_EXIT : S_DONE;
    assign st_n   = last ? follow : st;
    assign cnt_n  = last ? 6'd0 : cnt + 6'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            op        <= OP_RESET;
            len       <= '0;
            cnt       <= '0;
            data      <= '0;
            cap       <= '0;
            div       <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            tap_state <= TAP_TLR;
        end else begin
            rsp_valid <= 1'b0;
            case (st)
                S_IDLE: if (cmd_valid) begin
                    op        <= op_c;
                    len       <= len_c;
                    data      <= cmd_data;
                    cap       <= '0;
                    cnt       <= '0;
                    div       <= '0;
                    cmd_ready <= 1'b0;
                    st        <= st_0;
                    tms       <= tms_of(st_0, op_c, len_c, 6'd0);
                    tdi       <= 1'b0;
                end
                S_DONE: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= cap;
                    cmd_ready <= 1'b1;
                    st        <= S_IDLE;
                end
                default: begin
                    div <= div == DIV_LAST ? 16'd0 : div + 16'd1;
                    if (div == DIV_LAST) begin
                        tck <= ~tck;
                        if (!tck) begin
                            tap_state <= tap_nxt;
                            if (st == S_SHIFT) cap[cnt[IW-1:0]] <= tdo;
                        end else begin
                            // falling edge: move to the next TCK and present its TMS/TDI
                            st  <= st_n;
                            cnt <= cnt_n;
                            tms <= tms_of(st_n, op, len, cnt_n);
                            tdi <= st_n == S_SHIFT ? data[cnt_n[IW-1:0]] : 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_host_shifter.sv
// tb_jtag_host_shifter: randomized self-checking bench for jtag_host_shifter against a per-cycle waveform model
module tb_jtag_host_shifter;
    localparam int D  = 2;
    localparam int ML = 32;

    logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [5:0] cmd_len = '0;
    logic [ML-1:0] cmd_data = '0;
    logic cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
    logic [ML-1:0] rsp_data;
    logic [3:0] tap_state;

    jtag_host_shifter #(.CLK_DIV(D), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .tap_state(tap_state), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    logic loop = 1'b1, pat_bit = 1'b0;
    logic [63:0] pat = '0;
    assign tdo = loop ? tdi : pat_bit;

    // target TAP next-state tables indexed by state, for TMS=0 and TMS=1
    logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                              4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                              4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input bit q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v[i] = q[i];
        return v;
    endfunction

    // model: expected TCK list for the running command, and observed pin history
    bit active = 0;
    int j, ntck, off, L, k, r;
    bit tq[$], dq[$], obs_tms[$], obs_tdi[$];
    logic [3:0] traj[$];
    logic [3:0] mtap = 4'hF;
    logic [ML-1:0] exp_rsp, hold = '0;
    logic prev_tck = 1'b0;
    int rises = 0, rsps = 0;

    always @(negedge clk) begin
        if (rst) begin
            active = 0;
            mtap = 4'hF;
            hold = '0;
            prev_tck = 1'b0;
        end else begin
            if (tck && !prev_tck) begin
                rises++;
                obs_tms.push_back(tms);
                obs_tdi.push_back(tdi);
            end
            prev_tck = tck;
            if (rsp_valid) rsps++;
            chk("busy", 64'(busy), 64'(!cmd_ready));
            if (active) begin
                j++;
                if (j < 2 * D * ntck) begin
                    k = j / (2 * D);
                    r = j < D ? 0 : (j - D) / (2 * D) + 1;
                    chk("tck", 64'(tck), 64'((j % (2 * D)) >= D));
                    chk("tms", 64'(tms), 64'(tq[k]));
                    chk("tdi", 64'(tdi), 64'(dq[k]));
                    chk("ready_busy", 64'(cmd_ready), 64'(0));
                    chk("rsp_early", 64'(rsp_valid), 64'(0));
                    chk("tap_state", 64'(tap_state), 64'(traj[r]));
                    pat_bit = pat[k];
                end else if (j == 2 * D * ntck) begin
                    chk("tck_end", 64'(tck), 64'(0));
                    chk("ready_end", 64'(cmd_ready), 64'(0));
                    chk("rsp_early", 64'(rsp_valid), 64'(0));
                    chk("tap_end", 64'(tap_state), 64'(traj[ntck]));
                end else begin
                    chk("rsp_valid", 64'(rsp_valid), 64'(1));
                    chk("ready_done", 64'(cmd_ready), 64'(1));
                    chk("rsp_data", 64'(rsp_data), 64'(exp_rsp));
                    chk("tap_done", 64'(tap_state), 64'(traj[ntck]));
                    hold = exp_rsp;
                    mtap = traj[ntck];
                    active = 0;
                end
            end else begin
                chk("idle_tck", 64'(tck), 64'(0));
                chk("idle_rsp", 64'(rsp_valid), 64'(0));
                chk("idle_ready", 64'(cmd_ready), 64'(1));
                chk("idle_tap", 64'(tap_state), 64'(mtap));
                chk("rsp_hold", 64'(rsp_data), 64'(hold));
            end
            if (!active && cmd_valid) begin
                L = cmd_len > ML ? ML : int'(cmd_len);
                tq.delete();
                dq.delete();
                off = 0;
                exp_rsp = '0;
                if (cmd_op == 2'd0) begin
                    for (int i = 0; i < 6; i++) begin tq.push_back(i < 5); dq.push_back(0); end
                end else if (L > 0) begin
                    if (mtap == 4'hF) begin tq.push_back(0); dq.push_back(0); end
                    if (cmd_op == 2'd1) begin
                        for (int i = 0; i < L; i++) begin tq.push_back(0); dq.push_back(0); end
                    end else begin
                        tq.push_back(1); dq.push_back(0);
                        if (cmd_op == 2'd2) begin tq.push_back(1); dq.push_back(0); end
                        tq.push_back(0); dq.push_back(0);
                        tq.push_back(0); dq.push_back(0);
                        off = tq.size();
                        for (int i = 0; i < L; i++) begin tq.push_back(i == L - 1); dq.push_back(cmd_data[i]); end
                        tq.push_back(1); dq.push_back(0);
                        tq.push_back(0); dq.push_back(0);
                        for (int i = 0; i < L; i++) exp_rsp[i] = loop ? dq[off + i] : pat[off + i];
                    end
                end
                ntck = tq.size();
                traj.delete();
                traj.push_back(mtap);
                foreach (tq[i]) traj.push_back(tq[i] ? nxt1[traj[i]] : nxt0[traj[i]]);
                active = 1;
                j = -1;
            end
        end
    end

    task automatic start_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                             input logic lp, input logic [63:0] pt);
        @(posedge clk);
        #1;
        cmd_op = op; cmd_len = len; cmd_data = data; loop = lp; pat = pt; cmd_valid = 1'b1;
        rises = 0; rsps = 0; obs_tms.delete(); obs_tdi.delete();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
    endtask

    task automatic wait_rsp(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = cyc - t0; break; end
        end
        chk("rsp_seen", 64'(lat >= 0), 64'(1));
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                          input logic lp, input logic [63:0] pt, output int lat);
        int t0;
        start_cmd(op, len, data, lp, pt);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        t0 = cyc;
        wait_rsp(t0, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tck", 64'(tck), 64'(0));
        chk("rst_tms", 64'(tms), 64'(1));
        chk("rst_tdi", 64'(tdi), 64'(0));
        chk("rst_ready", 64'(cmd_ready), 64'(1));
        chk("rst_rsp", 64'(rsp_valid), 64'(0));
        chk("rst_data", 64'(rsp_data), 64'(0));
        chk("rst_tap", 64'(tap_state), 64'(4'hF));
        rst = 1'b0;

        do_cmd(2'd0, 6'd0, 32'h0, 1'b1, 64'h0, lat);
        chk("reset_tcks", 64'(rises), 64'(6));
        chk("reset_tms", pack(obs_tms), 64'h1F);
        chk("reset_lat", 64'(lat), 64'(25));
        chk("reset_tap", 64'(tap_state), 64'(4'hC));
        chk("reset_rsps", 64'(rsps), 64'(1));

        do_cmd(2'd2, 6'd6, 32'h09, 1'b1, 64'h0, lat);
        chk("ir_tcks", 64'(rises), 64'(12));
        chk("ir_tms", pack(obs_tms), 64'h603);
        chk("ir_tdi", pack(obs_tdi), 64'h090);
        chk("ir_data", 64'(rsp_data), 64'h09);
        chk("ir_tap", 64'(tap_state), 64'(4'hC));

        do_cmd(2'd3, 6'd32, 32'hDEADBEEF, 1'b1, 64'h0, lat);
        chk("dr32_tcks", 64'(rises), 64'(37));
        chk("dr32_data", 64'(rsp_data), 64'hDEADBEEF);
        chk("dr32_lat", 64'(lat), 64'(149));

        pulse_rst();
        do_cmd(2'd3, 6'd1, 32'h0, 1'b0, '1, lat);
        chk("dr1_tcks", 64'(rises), 64'(7));
        chk("dr1_tms", pack(obs_tms), 64'h32);
        chk("dr1_data", 64'(rsp_data), 64'h1);

        do_cmd(2'd3, 6'd0, 32'hFFFF_FFFF, 1'b1, 64'h0, lat);
        chk("dr0_tcks", 64'(rises), 64'(0));
        chk("dr0_lat", 64'(lat), 64'(1));
        chk("dr0_data", 64'(rsp_data), 64'h0);

        start_cmd(2'd1, 6'd10, 32'h0, 1'b1, 64'h0);
        wait_rsp(cyc, lat);
        chk("idle_first_tcks", 64'(rises), 64'(10));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_rsp(cyc, lat);
        chk("idle_second_lat", 64'(lat), 64'(41));
        @(posedge clk);
        #1;
        chk("idle_tcks", 64'(rises), 64'(20));
        chk("idle_tms", pack(obs_tms), 64'h0);
        chk("idle_rsps", 64'(rsps), 64'(2));
        chk("idle_data", 64'(rsp_data), 64'h0);

        start_cmd(2'd3, 6'd32, $urandom, 1'b1, 64'h0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 200 && rises < 8; i++) @(negedge clk);
        chk("mid_reached", 64'(rises), 64'(8));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_tck", 64'(tck), 64'(0));
        chk("mid_tms", 64'(tms), 64'(1));
        chk("mid_tap", 64'(tap_state), 64'(4'hF));
        chk("mid_ready", 64'(cmd_ready), 64'(1));
        chk("mid_rsp", 64'(rsp_valid), 64'(0));
        rsps = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_no_rsp", 64'(rsps), 64'(0));

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) pulse_rst();
            do_cmd(2'($urandom_range(0, 3)), 6'($urandom_range(0, 40)), $urandom,
                   1'($urandom_range(0, 1)), {$urandom, $urandom}, lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jtag_host_shifter.md
Name: jtag_host_shifter

Overview:
- JTAG initiator. It drives TCK/TMS/TDI toward a target TAP and captures TDO.
- Accepts high-level commands over a valid/ready interface: TAP reset, idle clocks, IR shift, DR shift.
- Generates the TMS walk by tracking the target's TAP state with the same next-state function the TAP uses.
- Sits between a debug/config master and the board-level JTAG pins.

Parameters:
- CLK_DIV, 2, clk cycles per TCK half-period (>=1).
- MAX_LEN, 32, max shift length in bits; sets cmd_data/rsp_data width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  host idle, able to accept a command
- cmd_op  in  2  0=RESET, 1=IDLE, 2=SHIFT_IR, 3=SHIFT_DR
- cmd_len  in  6  IDLE: TCK count; SHIFT: bit count 0..MAX_LEN
- cmd_data  in  MAX_LEN  TDI data, LSB shifted first
- rsp_valid  out  1  one-cycle pulse on command completion
- rsp_data  out  MAX_LEN  captured TDO, bit i = i-th shifted bit; bits >= len are 0
- busy  out  1  ~cmd_ready
- tap_state  out  4  tracked TAP state, IEEE encoding
- tck  out  1  JTAG clock, idles low
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to target
- tdo  in  1  JTAG data from target

Behaviour:
- Reset (async, immediate):
  - tck=0, tms=1, tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0.
  - tap_state=4'hF (Test-Logic-Reset).
  - An in-flight command is abandoned with no rsp_valid.
- TAP state encoding (IEEE 1149.1):
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- TCK period:
  - Low phase of CLK_DIV clk cycles, then high phase of CLK_DIV clk cycles.
  - tms/tdi update on the clk edge that starts a low phase (falling TCK).
  - On the clk edge that raises tck: tdo is sampled, and tap_state <= next(tap_state, tms).
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready drops the next cycle, and the first low phase starts that cycle.
  - cmd_valid while busy is ignored (no queuing).
- Prefix: if tap_state==TLR at the start of IDLE or SHIFT, one leading TCK with TMS=0 is emitted first (to RTI).
- RESET: 6 TCKs, TMS=1,1,1,1,1,0. Ends in RTI from any state.
- IDLE: cmd_len TCKs with TMS=0; stays in RTI. len=0 gives no TCKs.
- SHIFT_DR from RTI:
  - Walk TMS=1,0,0 (SelDR, CapDR, ShDR).
  - Then len TCKs: TMS=0 except TMS=1 on the last bit (enters Ex1DR).
  - Then TMS=1 (UpdDR), TMS=0 (RTI).
  - Total len+5 TCKs.
- SHIFT_IR: same as SHIFT_DR with walk TMS=1,1,0,0. Total len+6 TCKs.
- TDI/TDO bit timing: TDI for bit i is driven on the falling edge before the rising edge that samples TDO bit i. TDI=0 outside Shift states.
- SHIFT len=0: no TCKs; rsp_valid the cycle after accept, with rsp_data=0.
- Completion:
  - When the last high phase ends (tck back to 0), the next cycle pulses rsp_valid=1 and raises cmd_ready=1.
  - rsp_data holds until the next rsp_valid; RESET/IDLE report 0.
  - No backpressure on the response.
- Latency example: SHIFT_DR len n from RTI = (n+5)*2*CLK_DIV clk cycles from accept to last tck fall, +1 to rsp_valid.
- cmd_len > MAX_LEN is clamped to MAX_LEN.

Decomposition:
- Package jtag_pkg:
  - 4-bit TAP state localparams (encoding above).
  - cmd_op codes.
- Sub-module jtag_tap_next: combinational (state, tms) -> state_nxt, instantiated for tap_state tracking.
- The host sequencer FSM (IDLE, PREFIX, WALK, SHIFT, EXIT, DONE) lives in jtag_host_shifter.

Test Plan:
- Reset, then RESET cmd, CLK_DIV=2 -> 6 TCKs (24 clk), TMS 1,1,1,1,1,0, tap_state=C, one rsp_valid.
- SHIFT_IR len=6, data=0x09, tdo looped to tdi:
  - TMS 1,1,0,0,0,0,0,0,0,1,1,0.
  - TDI bits 1,0,0,1,0,0.
  - rsp_data=0x09, tap_state=C.
- SHIFT_DR len=32, data=0xDEADBEEF, loopback -> 37 TCKs, rsp_data=0xDEADBEEF, rsp_valid 149 clk after accept.
- SHIFT_DR len=1 straight after reset (TLR), tdo=1:
  - Leading TMS=0 prefix, then TMS 1,0,0,1,1,0; 7 TCKs total.
  - rsp_data=1.
- IDLE len=10 while cmd_valid held high -> 10 TCKs with TMS=0, second command accepted only after rsp_valid.
- Assert rst mid SHIFT_DR (bit 5) -> tck=0, tms=1, tap_state=F, cmd_ready=1 immediately, no rsp_valid.
